hasti_poci_bridge: RTL and testbench

HASTI_POCI_BRIDGE -- requirements
Module: hasti_poci_bridge

---
 rtl/pk_hasti.sv | 24 ++
 rtl/pk_poci.sv | 18 +
 rtl/if_poci.sv | 32 +++
 rtl/hasti_poci_bridge.sv | 159 +++++++++++++++
 tb/tb_hasti_poci_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pk_hasti.sv
`default_nettype none
// ============================================================================
// Package  : pk_hasti
// Brief    : Shared HASTI bus encodings (transfer types, response codes) and
//            bus widths used by every HASTI-facing block.
// Revision : 1.0 - initial release
// ============================================================================
package pk_hasti;

    localparam int unsigned c_HADDR_W = 32;
    localparam int unsigned c_HDATA_W = 32;

    // htrans encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // hresp encodings
    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pk_poci.sv
`default_nettype none
// ============================================================================
// Package  : pk_poci
// Brief    : POCI bus widths and the address map of the POCI segment that
//            sits behind the HASTI bridge.
// Revision : 1.0 - initial release
// ============================================================================
package pk_poci;

    localparam int unsigned c_PADDR_W = 32;
    localparam int unsigned c_PDATA_W = 32;

    // Address window decoded to the POCI segment.
    localparam logic [31:0] c_POCI_BASE = 32'h0000_0000;
    localparam logic [31:0] c_POCI_SIZE = 32'h0001_0000;

endpackage
`default_nettype wire

// File: rtl/if_poci.sv
`default_nettype none
// ============================================================================
// Interface : if_poci
// Brief     : POCI bus bundle.
//             modport n : requester (drives psel/paddr/penable/pwrite/pwdata)
//             modport s : completer (drives prdata/pready/pslverr)
// Revision  : 1.0 - initial release
// ============================================================================
interface if_poci;
    import pk_poci::*;

    logic                 psel;
    logic [c_PADDR_W-1:0] paddr;
    logic                 penable;
    logic                 pwrite;
    logic [c_PDATA_W-1:0] pwdata;
    logic [c_PDATA_W-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport n (
        output psel, paddr, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport s (
        input  psel, paddr, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface
`default_nettype wire

// File: rtl/hasti_poci_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hasti_poci_bridge
// Brief    : Single-clock bridge from a HASTI completer port to a POCI
//            requester port. One POCI transfer (SETUP + ACCESS) per accepted
//            NONSEQ/SEQ address phase; IDLE/BUSY get a zero-wait OKAY.
// Ports    : pclk, presetn      - clock, asynchronous active-low reset
//            haddr..hwdata      - HASTI address/control/write data (inputs)
//            hrdata/hready/hresp- HASTI read data / ready / response
//            p                  - POCI requester (if_poci.n)
// Options  : HASTI_POCI_PSLVERR_EN - when defined, pslverr in the final
//            ACCESS cycle produces a two-cycle HASTI ERROR response.
// Revision : 1.0 - initial release
// ============================================================================
module hasti_poci_bridge
    import pk_hasti::*;
    import pk_poci::*;
(
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [c_HADDR_W-1:0] haddr,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [2:0]           hburst,
    input  logic                 hmastlock,
    input  logic [3:0]           hprot,
    input  logic [1:0]           htrans,
    input  logic [c_HDATA_W-1:0] hwdata,
    output logic [c_HDATA_W-1:0] hrdata,
    output logic                 hready,
    output logic                 hresp,
    if_poci.n                    p
);

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_SETUP  = 2'd1;
    localparam state_t c_ST_ACCESS = 2'd2;
`ifdef HASTI_POCI_PSLVERR_EN
    localparam state_t c_ST_ERR    = 2'd3;
`endif

    state_t                 r_state;
    state_t                 w_state_d;
    logic [c_PADDR_W-1:0]   r_paddr;
    logic [c_PADDR_W-1:0]   w_paddr_d;
    logic                   r_pwrite;
    logic                   w_pwrite_d;
    logic                   w_htrans_act;
    logic                   w_addr_acc;
    logic                   w_psel;
    logic                   w_penable;
    logic                   w_unused;
`ifdef HASTI_POCI_PSLVERR_EN
    // Distinguishes the second ERR cycle (hready=1) from the first.
    logic                   r_err_last;
    logic                   w_err_last_d;
`endif

    assign w_htrans_act = (htrans == c_HTRANS_NONSEQ) || (htrans == c_HTRANS_SEQ);

    always_comb begin
        w_state_d  = r_state;
        w_paddr_d  = r_paddr;
        w_pwrite_d = r_pwrite;
        w_psel     = 1'b0;
        w_penable  = 1'b0;
        hready     = 1'b1;
        w_addr_acc = 1'b0;
`ifdef HASTI_POCI_PSLVERR_EN
        w_err_last_d = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_addr_acc = w_htrans_act;
            end
            c_ST_SETUP: begin
                w_psel    = 1'b1;
                hready    = 1'b0;
                w_state_d = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                hready    = p.pready;
`ifdef HASTI_POCI_PSLVERR_EN
                // Hold hready low so the master does not see an OKAY
                // completion before the ERROR response starts.
                if (p.pready && p.pslverr) begin
                    hready    = 1'b0;
                    w_state_d = c_ST_ERR;
                end else
`endif
                if (p.pready) begin
                    // Pipelined address phase may be taken in the last
                    // ACCESS cycle, giving a direct ACCESS -> SETUP hop.
                    w_addr_acc = w_htrans_act;
                    w_state_d  = c_ST_IDLE;
                end
            end
`ifdef HASTI_POCI_PSLVERR_EN
            c_ST_ERR: begin
                // Address phases seen in the second ERR cycle are dropped.
                hready       = r_err_last;
                w_err_last_d = ~r_err_last;
                if (r_err_last) begin
                    w_state_d = c_ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase

        if (w_addr_acc) begin
            w_state_d  = c_ST_SETUP;
            w_paddr_d  = haddr;
            w_pwrite_d = hwrite;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state    <= c_ST_IDLE;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
`ifdef HASTI_POCI_PSLVERR_EN
            r_err_last <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_paddr    <= w_paddr_d;
            r_pwrite   <= w_pwrite_d;
`ifdef HASTI_POCI_PSLVERR_EN
            r_err_last <= w_err_last_d;
`endif
        end
    end

    assign p.psel    = w_psel;
    assign p.penable = w_penable;
    assign p.paddr   = r_paddr;
    assign p.pwrite  = r_pwrite;
    // Master holds hwdata stable while hready is low.
    assign p.pwdata  = hwdata;
    assign hrdata    = p.prdata;

`ifdef HASTI_POCI_PSLVERR_EN
    assign hresp    = (r_state == c_ST_ERR) ? c_HRESP_ERROR : c_HRESP_OKAY;
    assign w_unused = ^{hsize, hburst, hmastlock, hprot};
`else
    assign hresp    = c_HRESP_OKAY;
    assign w_unused = ^{hsize, hburst, hmastlock, hprot, p.pslverr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hasti_poci_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hasti_poci_bridge
// Brief    : Self-checking bench for hasti_poci_bridge. A HASTI master issues
//            directed and random transfers, a POCI slave model answers with
//            planned wait states / data / errors, and a negedge monitor pops
//            expected responses from a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hasti_poci_bridge;
    import pk_hasti::*;

`ifdef HASTI_POCI_PSLVERR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  htrans;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } item_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err_resp;
        int          lat;
    } exp_t;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } slv_t;

    logic        pclk;
    logic        presetn;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    if_poci u_if ();

    hasti_poci_bridge u_dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hmastlock (hmastlock),
        .hprot     (hprot),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp),
        .p         (u_if)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int    checks = 0;
    int    errors = 0;

    item_t plan[$];
    exp_t  exp_q[$];
    slv_t  slv_q[$];

    item_t cur;
    logic  cur_valid;
    logic  hr_s;
    logic  hresp_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_active(input logic [1:0] t);
        return (t == c_HTRANS_NONSEQ) || (t == c_HTRANS_SEQ);
    endfunction

    function automatic item_t mk(input logic [1:0] t, input logic [31:0] a, input logic w,
                                 input logic [31:0] wd, input int ws, input logic [31:0] rd,
                                 input logic e);
        item_t it;
        it.htrans = t;  it.addr = a;  it.write = w;  it.wdata = wd;
        it.waits  = ws; it.rdata = rd; it.err = e;
        return it;
    endfunction

    function automatic item_t rand_item();
        item_t it;
        int    r;
        r = int'($urandom_range(0, 9));
        if (r < 3) it.htrans = (r == 0) ? c_HTRANS_BUSY : c_HTRANS_IDLE;
        else       it.htrans = (r < 6) ? c_HTRANS_NONSEQ : c_HTRANS_SEQ;
        it.addr  = $urandom & 32'h0000_FFFC;
        it.write = 1'($urandom_range(0, 1));
        it.wdata = $urandom;
        it.waits = int'($urandom_range(0, 3));
        it.rdata = $urandom;
        it.err   = ($urandom_range(0, 7) == 0);
        return it;
    endfunction

    // HASTI master: runs just after each rising edge, using hready/hresp
    // sampled at the preceding falling edge to know what the edge did.
    task automatic master_step();
        exp_t e;
        slv_t s;
        if (hr_s) begin
            if (cur_valid && is_active(cur.htrans)) begin
                e.addr     = cur.addr;
                e.write    = cur.write;
                e.wdata    = cur.wdata;
                e.rdata    = cur.rdata;
                e.err_resp = c_ERR_EN && cur.err;
                // Address phase, SETUP, ACCESS (+waits), plus two ERR cycles.
                e.lat      = 2 + cur.waits + (e.err_resp ? 2 : 0);
                exp_q.push_back(e);
                s.waits = cur.waits;
                s.rdata = cur.rdata;
                s.err   = cur.err;
                slv_q.push_back(s);
                hwdata = cur.wdata;
            end else begin
                hwdata = $urandom;
            end
            cur_valid = 1'b0;
            if (plan.size() > 0) begin
                cur       = plan.pop_front();
                cur_valid = 1'b1;
            end
        end else if (hresp_s && cur_valid) begin
            // First ERROR cycle: cancel the pending address and retry later.
            plan.push_front(cur);
            cur_valid = 1'b0;
        end
        if (cur_valid) begin
            htrans = cur.htrans;
            haddr  = cur.addr;
            hwrite = cur.write;
        end else begin
            htrans = c_HTRANS_IDLE;
            haddr  = $urandom;
            hwrite = 1'($urandom_range(0, 1));
        end
        hburst    = 3'($urandom_range(0, 7));
        hprot     = 4'($urandom_range(0, 15));
        hmastlock = 1'($urandom_range(0, 1));
    endtask

    task automatic cycle();
        @(negedge pclk);
        hr_s    = hready;
        hresp_s = hresp;
        @(posedge pclk);
        #1;
        master_step();
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((plan.size() > 0 || cur_valid || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain", (plan.size() > 0 || cur_valid || exp_q.size() > 0) ? 64'd1 : 64'd0, 64'd0);
        repeat (3) cycle();
    endtask

    // POCI completer model: replays the wait/data/error plan per transfer.
    slv_t s_cur;
    int   s_left;
    initial begin
        u_if.pready  = 1'b0;
        u_if.pslverr = 1'b0;
        u_if.prdata  = '0;
        s_left       = 0;
        s_cur.waits  = 0;
        s_cur.rdata  = '0;
        s_cur.err    = 1'b0;
        forever begin
            @(posedge pclk);
            #2;
            if (!presetn) begin
                slv_q.delete();
                s_left       = 0;
                u_if.pready  = 1'b0;
                u_if.pslverr = 1'b0;
            end else if (u_if.psel && !u_if.penable) begin
                if (slv_q.size() > 0) begin
                    s_cur = slv_q.pop_front();
                end else begin
                    s_cur.waits = 0;
                    s_cur.rdata = '0;
                    s_cur.err   = 1'b0;
                end
                s_left       = s_cur.waits;
                u_if.pready  = 1'b0;
                u_if.pslverr = 1'($urandom_range(0, 1));
                u_if.prdata  = $urandom;
            end else if (u_if.psel && u_if.penable) begin
                if (s_left == 0) begin
                    u_if.pready  = 1'b1;
                    u_if.pslverr = s_cur.err;
                    u_if.prdata  = s_cur.rdata;
                end else begin
                    s_left--;
                    u_if.pready  = 1'b0;
                    u_if.pslverr = 1'($urandom_range(0, 1));
                    u_if.prdata  = $urandom;
                end
            end else begin
                u_if.pready  = 1'($urandom_range(0, 1));
                u_if.pslverr = 1'($urandom_range(0, 1));
                u_if.prdata  = $urandom;
            end
        end
    end

    // Monitor: compares the DUT against the scoreboard at every falling edge.
    logic mon_active = 1'b0;
    int   mon_cnt    = 0;
    exp_t me;
    always @(negedge pclk) begin
        if (!presetn) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
            exp_q.delete();
        end else begin
            if (mon_active) begin
                mon_cnt++;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                    mon_active = 1'b0;
                end else begin
                    me = exp_q[0];
                    if (u_if.psel)
                        chk("paddr_pwrite_hold", {u_if.pwrite, u_if.paddr}, {me.write, me.addr});
                    if (mon_cnt == 1)
                        chk("setup_phase", {u_if.psel, u_if.penable, hready}, 3'b100);
                    if (mon_cnt == 2)
                        chk("access_phase", {u_if.psel, u_if.penable}, 2'b11);
                    if (me.write && u_if.psel && u_if.penable && u_if.pready)
                        chk("pwdata", u_if.pwdata, me.wdata);
                    if (me.err_resp && mon_cnt == me.lat - 1)
                        chk("err_first_cycle", {u_if.psel, hready, hresp}, 3'b001);
                    if (hready) begin
                        chk("latency", mon_cnt, me.lat);
                        chk("hresp", hresp, me.err_resp);
                        if (!me.write && !me.err_resp)
                            chk("hrdata", hrdata, me.rdata);
                        void'(exp_q.pop_front());
                        mon_active = 1'b0;
                    end else if (mon_cnt > me.lat + 4) begin
                        chk("stall_bound", mon_cnt, me.lat);
                        void'(exp_q.pop_front());
                        mon_active = 1'b0;
                    end
                end
            end else begin
                chk("idle_state", {u_if.psel, hready, hresp}, 3'b010);
            end
            if (hready && !hresp && is_active(htrans)) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        presetn   = 1'b0;
        htrans    = c_HTRANS_NONSEQ;
        haddr     = 32'hFFFF_FFF0;
        hwrite    = 1'b1;
        hwdata    = 32'h0;
        hsize     = 3'b010;
        hburst    = 3'b000;
        hmastlock = 1'b0;
        hprot     = 4'h0;
        cur_valid = 1'b0;
        hr_s      = 1'b1;
        hresp_s   = 1'b0;
        cur       = mk(c_HTRANS_IDLE, 0, 0, 0, 0, 0, 0);

        // Reset holds outputs even with an active address phase present.
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("reset_state", {u_if.psel, u_if.penable, u_if.pwrite, hready, hresp}, 5'b00010);
        chk("reset_paddr", u_if.paddr, 64'd0);
        @(posedge pclk);
        #1;
        htrans = c_HTRANS_IDLE;
        #2;
        presetn = 1'b1;

        // Directed scenarios.
        plan.push_back(mk(c_HTRANS_IDLE,   32'h0,         0, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_1004, 1, 32'hA5A5_0001, 0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_IDLE,   32'h0,         0, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_2000, 0, 32'h0,         3, 32'h1234_5678, 0));
        plan.push_back(mk(c_HTRANS_IDLE,   32'h0,         0, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_0000, 0, 32'h0,         0, 32'hCAFE_0000, 0));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_1000, 0, 32'h0,         0, 32'hCAFE_1000, 0));
        plan.push_back(mk(c_HTRANS_IDLE,   32'h0,         0, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_3000, 1, 32'h0BAD_F00D, 0, 32'h0,         1));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_3004, 0, 32'h0,         1, 32'h7777_0001, 0));
        plan.push_back(mk(c_HTRANS_IDLE,   32'h0000_4000, 1, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_BUSY,   32'h0000_4004, 1, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_BUSY,   32'h0000_4008, 0, 32'h0,         0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_IDLE,   32'h0000_400C, 0, 32'h0,         0, 32'h0,         0));
        run_drain(500);

        // Reset pulsed while the slave stalls in ACCESS.
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_2008, 1, 32'hDEAD_0001, 10, 32'h0, 0));
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(u_if.psel && u_if.penable) && n < 20);
        chk("reach_access", {u_if.psel, u_if.penable}, 2'b11);
        #2;
        presetn = 1'b0;
        #1;
        chk("reset_abort", {u_if.psel, u_if.penable, hready, hresp}, 4'b0010);
        cur_valid = 1'b0;
        htrans    = c_HTRANS_IDLE;
        @(posedge pclk);
        @(posedge pclk);
        #3;
        presetn = 1'b1;
        hr_s    = 1'b1;
        hresp_s = 1'b0;
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_200C, 1, 32'h5A5A_0002, 0, 32'h0,         0));
        plan.push_back(mk(c_HTRANS_NONSEQ, 32'h0000_2010, 0, 32'h0,         2, 32'h8765_4321, 0));
        run_drain(200);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) plan.push_back(rand_item());
        run_drain(5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
